card_dealer: RTL
================

Name: card_dealer

Overview:
- Upstream feeder for the 7-segment card decoders; six instances of the decoder consume this block's slot outputs.
- A free-running 1..13 counter models a shuffled deck. On a deal request, the current count is captured into one of six hand slots: player 1-3 or banker 1-3.
- Holds all dealt cards and registered baccarat hand scores for the round controller.

Parameters:
- MIN_CARD, 1, lowest card code produced (ace).
- MAX_CARD, 13, highest card code produced (king); the counter wraps from here to MIN_CARD.

Ports:
- clk  in  1  system clock, single domain
- resetb  in  1  synchronous active-low reset
- deal_req  in  1  request to deal one card; sampled only in IDLE
- slot_sel  in  3  target slot: 0-2 = pcard1-3, 3-5 = dcard1-3, 6-7 invalid
- clear  in  1  blanks all slots and scores; aborts any transaction
- busy  out  1  high whenever state != IDLE
- deal_ack  out  1  one-cycle completion pulse
- deal_err  out  1  one-cycle pulse, coincident with deal_ack, for an invalid slot_sel
- deal_card  out  4  card captured by the last transaction
- pcard1, pcard2, pcard3  out  4 each  player slots; 0 = empty, displays blank
- dcard1, dcard2, dcard3  out  4 each  banker slots; 0 = empty
- pscore  out  4  player hand score, 0-9
- dscore  out  4  banker hand score, 0-9

Behaviour:
- Reset: resetb is sampled on the rising clk edge. It forces:
  - all slots, deal_card, pscore and dscore to 0;
  - deal_ack, deal_err and busy to 0;
  - state to IDLE;
  - the counter to MIN_CARD.
- Counter: increments on every edge. MAX_CARD wraps to MIN_CARD. It never holds and never takes values outside MIN..MAX.
  - In the k-th cycle after reset release (k=0 first), count = (k mod 13) + 1.
- State machine: IDLE -> CAPTURE -> ACK -> IDLE.
  - IDLE: if deal_req=1 at an edge, latch count into deal_card and slot_sel into an internal register, then go to CAPTURE.
  - CAPTURE: write deal_card into the selected slot (no write if invalid), then go to ACK.
  - ACK: deal_ack=1 (and deal_err=1 if invalid) for exactly this cycle, then go to IDLE.
- Latency: request seen at edge N; slot updated at edge N+1; ack visible after edge N+1; IDLE again at edge N+2. Throughput is one card per 3 cycles.
- Ignored inputs: deal_req outside IDLE is ignored (no queueing), as is a held deal_req during the transaction.
  - Requests held high continuously re-trigger on each return to IDLE.
- Overwrite: an occupied slot is overwritten with no error.
- Clear:
  - At an edge, clear zeroes all slots and scores and returns to IDLE. deal_card and the counter are unaffected.
  - No ack is issued for an aborted transaction.
  - clear has priority over deal_req at the same edge.
  - clear during CAPTURE suppresses the write.
- Scores: registered, updated the edge after any slot change (slot write at N+1, score valid after N+2).
  - Card value: 0 -> 0; 1-9 -> face value; 10-13 -> 0.
  - pscore = (v(pcard1)+v(pcard2)+v(pcard3)) mod 10. dscore is the same over the dcard slots.
  - The intermediate sum is at least 5 bits wide (max 27).
- Reset mid-transaction: behaves as full reset; no ack is issued.

Optional Feature:
- Macro CARD_FORCE_EN.
- Defined: adds input ports force_en (1 bit) and force_card (4 bits).
  - At capture, if force_en=1 and force_card is in MIN..MAX, deal_card = force_card.
  - Otherwise the counter value is used.
  - The counter keeps running regardless.
- Undefined: both ports are absent; capture always uses the counter.

Decomposition:
- Package card_pkg:
  - card code localparams: CARD_EMPTY=0, ACE=1, TEN=10, JACK=11, QUEEN=12, KING=13;
  - dealer state enum {IDLE, CAPTURE, ACK};
  - slot index constants;
  - function card_value(code) returning 0-9.
- Sub-module hand_score: three 4-bit cards in, 4-bit mod-10 score out (combinational). card_dealer instantiates it twice and registers the outputs.

Test Plan:
- Counter/deal: reset, release, deal_req=1 with slot_sel=0 in cycle k=4 -> pcard1=5 after the next edge; deal_ack pulses once; busy high for 2 cycles.
- Wrap: request in cycle k=12 (count 13) to slot 3, then in cycle k=15 (count 3) to slot 4 -> dcard1=13, dcard2=3, dscore=3.
- Scores (CARD_FORCE_EN): force 9, 8, 7 into slots 0-2 -> pscore=4. Force 10, 11, 12 into slots 3-5 -> dscore=0.
- Invalid slot: slot_sel=6 -> deal_ack=1 and deal_err=1 in the same cycle; all slots unchanged.
- Clear priority: clear=1 in the CAPTURE cycle of a deal to slot 1 -> pcard2 stays 0, no deal_ack, busy=0 next cycle.
- Reset/ignore: deal_req pulsed during ACK is not dealt. Then resetb=0 during CAPTURE -> all outputs 0 next cycle and the counter restarts at 1.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card codes, dealer state encoding, slot indices and the baccarat
// card-value rule used by the card dealer and its hand scorers.
package card_pkg;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] ACE        = 4'd1;
  localparam logic [3:0] TEN        = 4'd10;
  localparam logic [3:0] JACK       = 4'd11;
  localparam logic [3:0] QUEEN      = 4'd12;
  localparam logic [3:0] KING       = 4'd13;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} dealer_state_t;

  localparam logic [2:0] SLOT_P1 = 3'd0;
  localparam logic [2:0] SLOT_P2 = 3'd1;
  localparam logic [2:0] SLOT_P3 = 3'd2;
  localparam logic [2:0] SLOT_D1 = 3'd3;
  localparam logic [2:0] SLOT_D2 = 3'd4;
  localparam logic [2:0] SLOT_D3 = 3'd5;

  // Ace through nine count at face value; empty, ten and court cards count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= ACE && code < TEN) return code;
    else return 4'd0;
  endfunction

endpackage

// File: rtl/card_dealer_hand_score.sv
// Combinational baccarat hand score: three card codes in, mod-10 total out.
module hand_score
  import card_pkg::*;
(
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
  output logic [3:0] score
);

  logic [4:0] sum;
  logic [4:0] modsum;

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    sum = {1'b0, card_value(card1)} + {1'b0, card_value(card2)}
        + {1'b0, card_value(card3)};
    if (sum >= 5'd20)      modsum = sum - 5'd20;
    else if (sum >= 5'd10) modsum = sum - 5'd10;
    else                   modsum = sum;
    score = modsum[3:0];
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: free-running MIN..MAX card counter captured into six hand slots,
// with registered player/banker scores. Define CARD_FORCE_EN to add force_en/force_card.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [3:0] MIN_CARD = 4'd1,
  parameter logic [3:0] MAX_CARD = 4'd13
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic [2:0] slot_sel,
  input  logic       clear,
`ifdef CARD_FORCE_EN
  input  logic       force_en,
  input  logic [3:0] force_card,
`endif
  output logic       busy,
  output logic       deal_ack,
  output logic       deal_err,
  output logic [3:0] deal_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore
);

  dealer_state_t state;
  logic [3:0]    count;
  logic [2:0]    sel_q;
  logic [3:0]    slot [6];
  logic [3:0]    next_card;
  logic [3:0]    pscore_c;
  logic [3:0]    dscore_c;

  assign pcard1 = slot[SLOT_P1];
  assign pcard2 = slot[SLOT_P2];
  assign pcard3 = slot[SLOT_P3];
  assign dcard1 = slot[SLOT_D1];
  assign dcard2 = slot[SLOT_D2];
  assign dcard3 = slot[SLOT_D3];

`ifdef CARD_FORCE_EN
  always_comb begin
    if (force_en && force_card >= MIN_CARD && force_card <= MAX_CARD) next_card = force_card;
    else next_card = count;
  end
`else
  assign next_card = count;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetb)               count <= MIN_CARD;
    else if (count >= MAX_CARD) count <= MIN_CARD;
    else                        count <= count + 4'd1;
  end

  hand_score u_pscore (.card1(slot[SLOT_P1]), .card2(slot[SLOT_P2]), .card3(slot[SLOT_P3]), .score(pscore_c));
  hand_score u_dscore (.card1(slot[SLOT_D1]), .card2(slot[SLOT_D2]), .card3(slot[SLOT_D3]), .score(dscore_c));

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state     <= IDLE;
      busy      <= 1'b0;
      deal_ack  <= 1'b0;
      deal_err  <= 1'b0;
      deal_card <= CARD_EMPTY;
      sel_q     <= SLOT_P1;
      pscore    <= 4'd0;
      dscore    <= 4'd0;
      // NOTE: the slot array is only six registers and 0 means "empty",
      // so it is reset explicitly rather than left to a memory init.
      for (int i = 0; i < 6; i++) slot[i] <= CARD_EMPTY;
    end else begin
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
      pscore   <= pscore_c;
      dscore   <= dscore_c;
      if (clear) begin
        // Abort: no ack, no pending write; deal_card and the counter survive.
        for (int i = 0; i < 6; i++) slot[i] <= CARD_EMPTY;
        pscore <= 4'd0;
        dscore <= 4'd0;
        state  <= IDLE;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (deal_req) begin
              deal_card <= next_card;
              sel_q     <= slot_sel;
              state     <= CAPTURE;
              busy      <= 1'b1;
            end
          end
          CAPTURE: begin
            if (sel_q <= SLOT_D3) slot[sel_q] <= deal_card;
            deal_ack <= 1'b1;
            deal_err <= (sel_q > SLOT_D3);
            state    <= ACK;
          end
          ACK: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
